// File: rtl/i_cache_ctrl.sv
// ---------------------------------------------------------------------------
// i_cache_ctrl
//   Direct-mapped instruction cache controller placed between the IF stage
//   and a 64x32 synchronous-read data RAM. Keeps the tag/valid arrays, looks
//   up fetch addresses, refills an 8-word line from memory on a miss and then
//   replays the fetch so every accepted request returns one instruction.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   if_req_*            fetch request (valid/ready handshake, byte address)
//   if_rsp_*            one-cycle instruction response pulse
//   fence_i             one-cycle pulse, invalidates every line
//   mem_req_*           line refill request (valid/ready handshake)
//   mem_rsp_*           refill beats, ascending word order
//   ram_*               data RAM port; read data arrives one cycle after
//                       the address is presented
//
// State      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a fetch; applies a pending fence first
// S_LOOKUP   | RAM word is on ram_data_i, compare tag and respond on hit
// S_MISS_REQ | refill request held on mem_req_* until accepted
// S_REFILL   | writing incoming beats into the RAM line
// S_REPLAY   | re-present the fetch address so the next lookup hits
// ---------------------------------------------------------------------------
module i_cache_ctrl #(
  parameter int ADDR_W = 64,
  parameter int OFF_W  = 3,
  parameter int IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_valid,
  output logic                   if_req_ready,
  input  logic [ADDR_W-1:0]      if_req_addr,
  output logic                   if_rsp_valid,
  output logic [31:0]            if_rsp_inst,
  input  logic                   fence_i,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  output logic [OFF_W+IDX_W-1:0] ram_addr_o,
  output logic [31:0]            ram_data_o,
  output logic                   ram_we_o,
  input  logic [31:0]            ram_data_i
);

  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W - 2;
  localparam int NLINES = 2 ** IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_REPLAY
  } state_t;

  state_t                   state_q;
  logic [ADDR_W-1:2]        addr_q;
  logic [NLINES-1:0]        valid_q;
  logic [TAG_W-1:0]         tag_mem [NLINES];
  logic [OFF_W-1:0]         cnt_q;
  logic                     fence_pend_q;
  logic [OFF_W+IDX_W-1:0]   ram_addr_q;

  logic [OFF_W-1:0]         word_q;
  logic [IDX_W-1:0]         idx_q;
  logic [TAG_W-1:0]         tag_q;
  logic [OFF_W-1:0]         req_word;
  logic [IDX_W-1:0]         req_idx;
  logic                     accept;
  logic                     refill_beat;
  logic                     last_beat;
  logic                     hit;
  logic                     unused_addr_bits;

  assign word_q   = addr_q[OFF_W+1:2];
  assign idx_q    = addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign tag_q    = addr_q[ADDR_W-1:OFF_W+IDX_W+2];
  assign req_word = if_req_addr[OFF_W+1:2];
  assign req_idx  = if_req_addr[OFF_W+IDX_W+1:OFF_W+2];

  // Byte offset within the instruction word carries no information here.
  assign unused_addr_bits = ^if_req_addr[1:0];

  // A fence arriving in IDLE blocks the request in the same cycle, so the
  // invalidation always lands before the next lookup.
  assign if_req_ready = rst && (state_q == S_IDLE) && !fence_pend_q && !fence_i;
  assign accept       = if_req_valid && if_req_ready;
  assign refill_beat  = (state_q == S_REFILL) && mem_rsp_valid;
  assign last_beat    = refill_beat && (&cnt_q);
  assign hit          = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);

  // The RAM samples its address at the end of the cycle it is presented, so
  // the address is driven combinationally in the accept/replay/beat cycle and
  // the read word is available during the following LOOKUP.
  always_comb begin
    ram_addr_o = ram_addr_q;
    ram_data_o = '0;
    ram_we_o   = 1'b0;
    if (accept) begin
      ram_addr_o = {req_idx, req_word};
    end else if (state_q == S_REPLAY) begin
      ram_addr_o = {idx_q, word_q};
    end else if (refill_beat) begin
      ram_we_o   = 1'b1;
      ram_addr_o = {idx_q, cnt_q};
      ram_data_o = mem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      valid_q       <= '0;
      cnt_q         <= '0;
      fence_pend_q  <= 1'b0;
      ram_addr_q    <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_inst   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ram_addr_q   <= ram_addr_o;
      if (fence_i) fence_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (fence_i || fence_pend_q) begin
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
          end else if (accept) begin
            addr_q  <= if_req_addr[ADDR_W-1:2];
            state_q <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            if_rsp_valid <= 1'b1;
            if_rsp_inst  <= ram_data_i;
            state_q      <= S_IDLE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {tag_q, idx_q, {(OFF_W + 2){1'b0}}};
            state_q       <= S_MISS_REQ;
          end
        end

        S_MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            valid_q[idx_q] <= 1'b0;
            cnt_q          <= '0;
            state_q        <= S_REFILL;
          end
        end

        S_REFILL: begin
          if (refill_beat) begin
            cnt_q <= cnt_q + OFF_W'(1);
            // A fence received mid-refill stays pending and clears this
            // line once the replayed fetch has completed.
            if (last_beat) begin
              valid_q[idx_q] <= 1'b1;
              state_q        <= S_REPLAY;
            end
          end
        end

        S_REPLAY: begin
          state_q <= S_LOOKUP;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (last_beat) tag_mem[idx_q] <= tag_q;
  end

endmodule

// File: tb/tb_i_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i_cache_ctrl
//   Scoreboard bench for i_cache_ctrl. A reference cache model (valid/tag per
//   line, fence-pending flag) predicts hit/miss and the instruction word for
//   every accepted fetch; a monitor compares responses, refill requests and
//   RAM writes. Memory contents are a fixed function of the word address.
// ---------------------------------------------------------------------------
module tb_i_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_req_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        fence_i = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [5:0]  ram_addr_o;
  logic [31:0] ram_data_o;
  logic        ram_we_o;
  logic [31:0] ram_data_i;

  always #5 clk = ~clk;

  i_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst), .fence_i(fence_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o),
    .ram_data_i(ram_data_i)
  );

  // 64x32 data RAM, one-cycle synchronous read
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o] <= ram_data_o;
    ram_data_i <= ram[ram_addr_o];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0] - 32'h8000_0000;
    return 32'h1000 + (lo >> 2);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] inst;
    bit          miss;
    int          acc_cyc;
    int          refills_at;
    logic [63:0] line;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  bit          rv [8];
  logic [55:0] rt [8];
  bit          fpend = 0;
  int          refills = 0;
  int          wbeat = 0;
  logic [2:0]  ix;

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < 8; k++) rv[k] = 0;
    fpend = 0;
    wbeat = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (if_rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected actual=%h required=no_response", if_rsp_inst);
        end else begin
          e = sb.pop_front();
          chk("rsp_inst", 64'(if_rsp_inst), 64'(e.inst));
          chk("rsp_miss", 64'(refills - e.refills_at), 64'(e.miss));
          if (e.miss) chk("refill_writes", 64'(wbeat), 64'd8);
          else        chk("hit_latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
      if (if_req_valid && if_req_ready) begin
        ix = if_req_addr[7:5];
        if (fpend) begin
          for (int k = 0; k < 8; k++) rv[k] = 0;
          fpend = 0;
        end
        e.miss       = !(rv[ix] && rt[ix] == if_req_addr[63:8]);
        e.inst       = mem_word({if_req_addr[63:2], 2'b00});
        e.line       = {if_req_addr[63:5], 5'b0};
        e.acc_cyc    = cyc;
        e.refills_at = refills;
        sb.push_back(e);
        rv[ix] = 1;
        rt[ix] = if_req_addr[63:8];
      end
      if (fence_i) fpend = 1;
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mem_req_unexpected actual=%h required=no_request", mem_req_addr);
        end else begin
          chk("mem_req_addr", mem_req_addr, sb[0].line);
        end
        refills++;
        wbeat = 0;
      end
      if (ram_we_o) begin
        if (sb.size() != 0) begin
          chk("ram_waddr", 64'(ram_addr_o), 64'({sb[0].line[7:5], 3'(wbeat)}));
          chk("ram_wdata", 64'(ram_data_o), 64'(mem_word(sb[0].line + 64'(wbeat) * 4)));
        end
        wbeat++;
      end else begin
        chk("ram_data_idle", 64'(ram_data_o), 64'd0);
      end
    end
  end

  // ---------------- memory responder ----------------
  int dly_fix = 0;
  int dly_max = 0;
  bit gaps = 0;

  initial begin
    logic [63:0] line;
    int dly;
    int b;
    forever begin
      @(posedge clk); #1;
      if (rst && mem_req_valid) begin
        line = mem_req_addr;
        dly  = (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, dly_max));
        for (int i = 0; i < dly && rst; i++) begin
          @(negedge clk);
          if (rst) begin
            chk("mem_req_valid_hold", 64'(mem_req_valid), 64'd1);
            chk("mem_req_addr_hold", mem_req_addr, line);
          end
          @(posedge clk); #1;
        end
        if (rst) begin
          mem_req_ready = 1'b1;
          @(posedge clk); #1;
          mem_req_ready = 1'b0;
        end
        b = 0;
        while (b < 8 && rst) begin
          if (gaps && $urandom_range(0, 2) == 0) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEAD_BEEF;
          end else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(line + 64'(b) * 4);
            b++;
          end
          @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fetch(input logic [63:0] a, input bit with_fence, output int n);
    bit acc;
    acc = 0;
    n   = 0;
    if_req_valid = 1'b1;
    if_req_addr  = a;
    fence_i      = with_fence;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = if_req_ready;
      @(posedge clk); #1;
      fence_i = 1'b0;
      n++;
    end
    if_req_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout actual=%0d_pending required=0", sb.size());
    end
  endtask

  task automatic wait_beats(input int r0, input int beats);
    int n;
    n = 0;
    while (!(refills == r0 + 1 && wbeat >= beats) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("refill_progress_seen", 64'(refills == r0 + 1 && wbeat >= beats), 64'd1);
  endtask

  task automatic reset_checks();
    chk("rst_if_req_ready", 64'(if_req_ready), 64'd0);
    chk("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    chk("rst_if_rsp_inst", 64'(if_rsp_inst), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_req_addr", mem_req_addr, 64'd0);
    chk("rst_ram_addr", 64'(ram_addr_o), 64'd0);
    chk("rst_ram_data", 64'(ram_data_o), 64'd0);
    chk("rst_ram_we", 64'(ram_we_o), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    logic [63:0] a;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(if_req_ready), 64'd1);
    @(posedge clk); #1;

    // cold miss, then hit in the same line
    dly_fix = 0; gaps = 0;
    fetch(64'h8000_0000, 0, n); wait_done();
    fetch(64'h8000_000C, 0, n); wait_done();

    // slow request acceptance, gapped beats
    dly_fix = 5; gaps = 1;
    fetch(64'h8000_0040, 0, n); wait_done();

    // conflicting tag on index 0 evicts the first line
    dly_fix = -1; dly_max = 3;
    fetch(64'h8000_0100, 0, n); wait_done();
    fetch(64'h8000_0000, 0, n); wait_done();

    // fence during refill: response still delivered, line then invalid
    r0 = refills;
    fetch(64'h8000_0020, 0, n);
    wait_beats(r0, 2);
    fence_i = 1'b1;
    @(posedge clk); #1;
    fence_i = 1'b0;
    wait_done();
    fetch(64'h8000_0024, 0, n); wait_done();

    // simultaneous fence and request in IDLE: accepted one cycle later
    fetch(64'h8000_0028, 1, n);
    chk("fence_wins_cycles", 64'(n), 64'd2);
    wait_done();

    // reset at refill beat 4, then full refill of the same address
    r0 = refills;
    fetch(64'h8000_0060, 0, n);
    wait_beats(r0, 4);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    fetch(64'h8000_0060, 0, n); wait_done();
    fetch(64'h8000_0064, 0, n); wait_done();

    // randomized traffic
    dly_fix = -1; dly_max = 4; gaps = 1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 0) a = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4;
      else                           a = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
      a[1:0] = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 9) == 0) begin
        fence_i = 1'b1;
        @(posedge clk); #1;
        fence_i = 1'b0;
      end
      fetch(a, $urandom_range(0, 11) == 0, n);
      if ($urandom_range(0, 2) == 0) wait_done();
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
